mat_stream_loader: RTL

//  Front-end sequencer for mat_2x2_multiplier: accepts matrix elements one per cycle on a

---
 rtl/mat_stream_loader.sv | 96 +++++++++
 1 files changed

// File: rtl/mat_stream_loader.sv
// mat_stream_loader: serial element loader and result serializer around a 2x2 matrix multiplier
module mat_stream_loader #(
   parameter int EW     = 4,
   parameter int RW     = 8,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [EW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [EW-1:0] a,
   output logic [EW-1:0] b,
   output logic [EW-1:0] c,
   output logic [EW-1:0] d,
   output logic [EW-1:0] e,
   output logic [EW-1:0] f,
   output logic [EW-1:0] g,
   output logic [EW-1:0] h,
   input  logic [RW-1:0] w,
   input  logic [RW-1:0] x,
   input  logic [RW-1:0] y,
   input  logic [RW-1:0] z,
   output logic [RW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [1:0] LOAD = 2'd0, WAIT = 2'd1, OUT = 2'd2;
   logic [1:0]    state;
   logic [2:0]    elem_cnt;
   logic [1:0]    beat_cnt;
   logic [SW-1:0] settle_cnt;
   logic [EW-1:0] shadow [0:6];
   logic [RW-1:0] res [0:3];
   assign out_data = res[beat_cnt];
   assign out_last = out_valid && beat_cnt == 2'd3;
   assign busy     = state != LOAD;
   // sequencer: gather eight elements, commit them atomically, wait for the multiplier, then serialize w,x,y,z
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= LOAD;
         elem_cnt   <= '0;
         beat_cnt   <= '0;
         settle_cnt <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         shadow     <= '{default: '0};
         res        <= '{default: '0};
         {a, b, c, d, e, f, g, h} <= '0;
      end else begin
         case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (elem_cnt == 3'd7) begin
                     {a, b, c, d} <= {shadow[0], shadow[1], shadow[2], shadow[3]};
                     {e, f, g, h} <= {shadow[4], shadow[5], shadow[6], in_data};
                     elem_cnt     <= '0;
                     settle_cnt   <= '0;
                     in_ready     <= 1'b0;
                     state        <= WAIT;
                  end else begin
                     shadow[elem_cnt] <= in_data;
                     elem_cnt         <= elem_cnt + 3'd1;
                  end
               end
            end
            WAIT: begin
               if (settle_cnt == SW'(SETTLE - 1)) begin
                  res       <= '{w, x, y, z};
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            OUT: begin
               if (out_valid && out_ready) begin
                  if (beat_cnt == 2'd3) begin
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                     beat_cnt  <= '0;
                     state     <= LOAD;
                  end else begin
                     beat_cnt <= beat_cnt + 2'd1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule
